// File: rtl/uart_transmitter.sv
// Buffered 8N1 UART transmitter: a circular-buffer FIFO feeding a registered
// serializer FSM. Back-to-back frames are sent with no idle gap between them.
module uart_transmitter #(
  parameter int CLOCKS_PER_BIT  = 868,
  parameter int FIFO_DEPTH_BITS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               write_data,
  input  logic                     write_enable,
  output logic                     ready,
  output logic [FIFO_DEPTH_BITS:0] fifo_count,
  output logic                     busy,
  output logic                     tx
);

  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
  localparam logic [CNT_W-1:0]         LAST_CNT = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [FIFO_DEPTH_BITS:0] FULL_CNT = (FIFO_DEPTH_BITS + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t                     r_state;
  state_t                     w_state_next;
  logic [7:0]                 r_mem [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] r_wr_ptr;
  logic [FIFO_DEPTH_BITS-1:0] r_rd_ptr;
  logic [FIFO_DEPTH_BITS:0]   r_count;
  logic [CNT_W-1:0]           r_bit_cnt;
  logic [CNT_W-1:0]           w_bit_cnt_next;
  logic [2:0]                 r_bit_idx;
  logic [2:0]                 w_bit_idx_next;
  logic [7:0]                 r_shift;
  logic                       r_tx;
  logic                       w_tx_next;
  logic                       w_push;
  logic                       w_pop;
  logic                       w_has_data;
  logic                       w_bit_done;

  assign ready      = (r_count != FULL_CNT);
  assign fifo_count = r_count;
  assign busy       = w_has_data || (r_state != S_IDLE);
  assign tx         = r_tx;

  assign w_push     = write_enable && ready;
  assign w_has_data = (r_count != '0);
  assign w_bit_done = (r_bit_cnt == LAST_CNT);

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage and shift register carry data only; reset leaves them untouched.
  always_ff @(posedge clk) begin
    if (w_push && !reset) r_mem[r_wr_ptr] <= write_data;
    if (w_pop)            r_shift <= r_mem[r_rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_bit_idx <= w_bit_idx_next;
      r_tx      <= w_tx_next;
    end
  end

  // tx is computed for the state being entered so the pin itself is a flop.
  always_comb begin
    w_state_next   = r_state;
    w_bit_cnt_next = w_bit_done ? '0 : r_bit_cnt + 1'b1;
    w_bit_idx_next = r_bit_idx;
    w_tx_next      = r_tx;
    w_pop          = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_bit_cnt_next = '0;
        w_tx_next      = 1'b1;
        if (w_has_data) begin
          w_pop        = 1'b1;
          w_state_next = S_START;
          w_tx_next    = 1'b0;
        end
      end
      S_START: begin
        if (w_bit_done) begin
          w_state_next   = S_DATA;
          w_bit_idx_next = '0;
          w_tx_next      = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_bit_done) begin
          if (r_bit_idx == 3'd7) begin
            w_state_next = S_STOP;
            w_tx_next    = 1'b1;
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
            w_tx_next      = r_shift[r_bit_idx + 3'd1];
          end
        end
      end
      S_STOP: begin
        if (w_bit_done) begin
          if (w_has_data) begin
            w_pop        = 1'b1;
            w_state_next = S_START;
            w_tx_next    = 1'b0;
          end else begin
            w_state_next = S_IDLE;
            w_tx_next    = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_tx_next    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter: accepted bytes are queued on write and
// compared against frames reconstructed from the tx line by a receiver model.
module tb_uart_transmitter;

  localparam int CPB = 4;
  localparam int FDB = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   write_data;
  logic         write_enable;
  logic         ready;
  logic [FDB:0] fifo_count;
  logic         busy;
  logic         tx;

  uart_transmitter #(
    .CLOCKS_PER_BIT (CPB),
    .FIFO_DEPTH_BITS(FDB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .write_data  (write_data),
    .write_enable(write_enable),
    .ready       (ready),
    .fifo_count  (fifo_count),
    .busy        (busy),
    .tx          (tx)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         frames_done = 0;
  int         start_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] last_rx = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Receiver model: compares every line cycle against the expected frame shape
  // and rebuilds the byte from mid-bit samples.
  initial begin
    bit         active;
    int         phase;
    int         bad;
    logic [9:0] frame;
    logic [7:0] rx;
    logic [7:0] head;
    active = 1'b0;
    phase  = 0;
    bad    = 0;
    frame  = '1;
    rx     = '0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        active = 1'b0;
      end else begin
        if (!active && tx === 1'b0) begin
          active = 1'b1;
          phase  = 0;
          bad    = 0;
          start_q.push_back(cyc);
          chk("frame_queued", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            head  = exp_q.pop_front();
            frame = {1'b1, head, 1'b0};
          end else begin
            frame = '1;
          end
        end
        if (active) begin
          if (tx !== frame[phase / CPB]) bad++;
          if ((phase % CPB) == CPB / 2 && phase >= CPB && phase < 9 * CPB)
            rx[phase / CPB - 1] = tx;
          phase++;
          if (phase == 10 * CPB) begin
            chk("frame_bits", bad, 0);
            chk("rx_byte", rx, frame[8:1]);
            last_rx = rx;
            frames_done++;
            active = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] b, input bit expect_ok);
    if (expect_ok) exp_q.push_back(b);
    write_enable = 1'b1;
    write_data   = b;
    step();
    write_enable = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n;
    n = 0;
    while (frames_done < target && n < budget) begin
      step();
      n++;
    end
    chk("frames_done", frames_done, target);
  endtask

  initial begin
    int c0;
    int f0;
    int s0;
    reset        = 1'b1;
    write_enable = 1'b0;
    write_data   = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    write_enable = 1'b1;
    write_data   = 8'hEE;
    step();
    chk("rst_tx", tx, 1);
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_count", fifo_count, 0);
    reset        = 1'b0;
    write_enable = 1'b0;
    step();
    chk("rst_write_dropped", fifo_count, 0);
    chk("rst_write_idle", busy, 0);

    // single byte latency and busy timing
    f0 = frames_done;
    c0 = cyc;
    put(8'h55, 1'b1);
    chk("lat_count1", fifo_count, 1);
    chk("lat_busy", busy, 1);
    chk("lat_tx_high", tx, 1);
    step();
    chk("lat_tx_low", tx, 0);
    chk("lat_count0", fifo_count, 0);
    while (cyc < c0 + 41) step();
    chk("busy_c41", busy, 1);
    step();
    chk("busy_c42", busy, 0);
    chk("single_frames", frames_done, f0 + 1);
    chk("single_start", start_q[start_q.size() - 1], c0 + 2);

    // bit order
    f0 = frames_done;
    put(8'hA3, 1'b1);
    wait_frames(f0 + 1, 60);
    chk("bit_order", last_rx, 8'hA3);

    // fill and overflow
    step();
    f0 = frames_done;
    s0 = start_q.size();
    c0 = cyc;
    for (int i = 1; i <= 6; i++) begin
      if (i == 5) chk("ovf_ready_c4", ready, 1);
      if (i == 6) begin
        chk("ovf_ready_c5", ready, 0);
        chk("ovf_count_c5", fifo_count, 4);
      end
      put(8'(i), i <= 5);
    end
    wait_frames(f0 + 5, 260);
    chk("ovf_first_start", start_q[s0], c0 + 2);
    for (int k = 1; k <= 4; k++)
      chk("ovf_gap", start_q[s0 + k] - start_q[s0 + k - 1], 40);
    step();
    chk("ovf_idle", busy, 0);
    repeat (45) step();
    chk("ovf_no_extra", frames_done, f0 + 5);

    // back-to-back extremes
    f0 = frames_done;
    s0 = start_q.size();
    put(8'h00, 1'b1);
    put(8'hFF, 1'b1);
    wait_frames(f0 + 2, 120);
    chk("b2b_gap", start_q[s0 + 1] - start_q[s0], 40);

    // write held while full, accepted as the serializer pops
    step();
    f0 = frames_done;
    c0 = cyc;
    for (int i = 0; i < 5; i++) put(8'h10 + 8'(i), 1'b1);
    chk("sim_full_ready", ready, 0);
    exp_q.push_back(8'h77);
    write_enable = 1'b1;
    write_data   = 8'h77;
    while (cyc < c0 + 43) begin
      if (cyc == c0 + 41) chk("sim_ready_c41", ready, 0);
      if (cyc == c0 + 42) begin
        chk("sim_ready_c42", ready, 1);
        chk("sim_count_c42", fifo_count, 3);
      end
      step();
    end
    write_enable = 1'b0;
    chk("sim_count_c43", fifo_count, 4);
    chk("sim_ready_c43", ready, 0);
    wait_frames(f0 + 6, 300);
    chk("sim_last", last_rx, 8'h77);

    // reset mid-frame during data bit 3
    step();
    f0 = frames_done;
    s0 = start_q.size();
    c0 = cyc;
    put(8'h81, 1'b1);
    put(8'h42, 1'b1);
    while (cyc < c0 + 19) step();
    chk("mid_tx_bit3", tx, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", ready, 1);
    repeat (50) step();
    chk("mid_no_frame", start_q.size(), s0 + 1);
    chk("mid_abort_count", frames_done, f0);
    chk("mid_idle", busy, 0);
    put(8'h3C, 1'b1);
    wait_frames(f0 + 1, 60);
    chk("mid_recover", last_rx, 8'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
